// File: rtl/cond_exec_unit.sv
// ARM conditional-execution unit: NZCV flag register, condition evaluation,
// pipeline-qualified write gating, saved-flags stack and saturating perf counters.
module cond_exec_unit #(
  parameter int unsigned FLAG_STACK_DEPTH = 4,
  parameter int unsigned PERF_CNT_W       = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Valid,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic [3:0]            Cond,
  input  logic [3:0]            ALUFlags,
  input  logic [1:0]            FlagW,
  input  logic                  PCS,
  input  logic                  RegW,
  input  logic                  MemW,
  input  logic                  NoWrite,
  input  logic                  FlagPush,
  input  logic                  FlagPop,
  output logic                  PCSrc,
  output logic                  RegWrite,
  output logic                  MemWrite,
  output logic                  CondEx,
  output logic [3:0]            Flags,
  output logic                  StackEmpty,
  output logic                  StackFull,
  output logic                  StackErr,
  output logic [PERF_CNT_W-1:0] ExecCount,
  output logic [PERF_CNT_W-1:0] SkipCount
);

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  localparam int unsigned SP_W  = $clog2(FLAG_STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (FLAG_STACK_DEPTH > 1) ? $clog2(FLAG_STACK_DEPTH) : 1;
  localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]      flags_q;
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_dec;
  logic [3:0]      stack [2**IDX_W];
  cond_e           cond;
  logic            n, z, c, v;
  logic            live, go;
  logic            push_ok, pop_ok, stack_fault;

  assign cond = cond_e'(Cond);
  assign {n, z, c, v} = flags_q;

  always_comb begin
    CondEx = 1'b0;
    case (cond)
      EQ: CondEx = z;
      NE: CondEx = !z;
      CS: CondEx = c;
      CC: CondEx = !c;
      MI: CondEx = n;
      PL: CondEx = !n;
      VS: CondEx = v;
      VC: CondEx = !v;
      HI: CondEx = c & !z;
      LS: CondEx = !c | z;
      GE: CondEx = (n == v);
      LT: CondEx = (n != v);
      GT: CondEx = !z & (n == v);
      LE: CondEx = z | (n != v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
    endcase
  end

  assign live     = Valid & !Stall & !Flush;
  assign go       = live & CondEx;
  assign PCSrc    = go & PCS;
  assign RegWrite = go & RegW & !NoWrite;
  assign MemWrite = go & MemW;

  assign Flags      = flags_q;
  assign StackEmpty = (sp == '0);
  assign StackFull  = (sp == SP_W'(FLAG_STACK_DEPTH));
  assign sp_dec     = sp - 1'b1;

  assign push_ok     = FlagPush & !FlagPop & !StackFull;
  assign pop_ok      = FlagPop & !FlagPush & !StackEmpty;
  assign stack_fault = (FlagPush | FlagPop) & !push_ok & !pop_ok;

  // A faulting stack request freezes Flags entirely, including any flag write.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      flags_q  <= '0;
      sp       <= '0;
      StackErr <= 1'b0;
    end else if (!Stall) begin
      if (stack_fault) begin
        StackErr <= 1'b1;
      end else if (pop_ok) begin
        flags_q <= stack[sp_dec[IDX_W-1:0]];
        sp      <= sp_dec;
      end else if (go) begin
        if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
      end
      if (push_ok) begin
        stack[sp[IDX_W-1:0]] <= flags_q;
        sp                   <= sp + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ExecCount <= '0;
      SkipCount <= '0;
    end else if (live) begin
      if (CondEx) begin
        if (ExecCount != CNT_MAX) ExecCount <= ExecCount + 1'b1;
      end else begin
        if (SkipCount != CNT_MAX) SkipCount <= SkipCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: a queue-based reference model predicts
// every cycle's outputs, a negedge monitor pops and compares them.
module tb_cond_exec_unit;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 2;

  logic          CLK = 1'b0;
  logic          Reset, Valid, Stall, Flush;
  logic [3:0]    Cond, ALUFlags;
  logic [1:0]    FlagW;
  logic          PCS, RegW, MemW, NoWrite, FlagPush, FlagPop;
  logic          PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]    Flags;
  logic          StackEmpty, StackFull, StackErr;
  logic [CW-1:0] ExecCount, SkipCount;

  always #5 CLK = ~CLK;

  cond_exec_unit #(.FLAG_STACK_DEPTH(DEPTH), .PERF_CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .Valid(Valid), .Stall(Stall), .Flush(Flush),
    .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
    .MemW(MemW), .NoWrite(NoWrite), .FlagPush(FlagPush), .FlagPop(FlagPop),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .StackEmpty(StackEmpty), .StackFull(StackFull),
    .StackErr(StackErr), .ExecCount(ExecCount), .SkipCount(SkipCount)
  );

  typedef struct packed {
    logic       rst, valid, stall, flush;
    logic [3:0] cond, alu;
    logic [1:0] fw;
    logic       pcs, regw, memw, nowr, push, pop;
  } stim_t;

  typedef struct packed {
    logic          pcsrc, regwrite, memwrite, condex;
    logic [3:0]    flags;
    logic          empty, full, err;
    logic [CW-1:0] exec, skip;
  } out_t;

  out_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // reference state
  bit       known = 0;
  bit [3:0] m_flags;
  bit [3:0] m_stack[$];
  bit       m_err;
  int       m_exec, m_skip;
  int       cnt_max = (1 << CW) - 1;

  function automatic bit cond_pass(input bit [3:0] c, input bit [3:0] f);
    bit fn = f[3], fz = f[2], fc = f[1], fv = f[0];
    case (c)
      4'd0:  return fz;
      4'd1:  return !fz;
      4'd2:  return fc;
      4'd3:  return !fc;
      4'd4:  return fn;
      4'd5:  return !fn;
      4'd6:  return fv;
      4'd7:  return !fv;
      4'd8:  return fc && !fz;
      4'd9:  return !fc || fz;
      4'd10: return fn == fv;
      4'd11: return fn != fv;
      4'd12: return !fz && (fn == fv);
      4'd13: return fz || (fn != fv);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic apply(input stim_t s);
    out_t e;
    bit   pass, live, go, fault;
    @(posedge CLK);
    #1;
    Reset = s.rst; Valid = s.valid; Stall = s.stall; Flush = s.flush;
    Cond = s.cond; ALUFlags = s.alu; FlagW = s.fw; PCS = s.pcs; RegW = s.regw;
    MemW = s.memw; NoWrite = s.nowr; FlagPush = s.push; FlagPop = s.pop;
    pass = cond_pass(s.cond, m_flags);
    live = s.valid && !s.stall && !s.flush;
    go   = live && pass;
    if (known) begin
      e.pcsrc    = go && s.pcs;
      e.regwrite = go && s.regw && !s.nowr;
      e.memwrite = go && s.memw;
      e.condex   = pass;
      e.flags    = m_flags;
      e.empty    = (m_stack.size() == 0);
      e.full     = (m_stack.size() == DEPTH);
      e.err      = m_err;
      e.exec     = CW'(m_exec);
      e.skip     = CW'(m_skip);
      exp_q.push_back(e);
    end
    if (s.rst) begin
      known = 1; m_flags = 0; m_stack.delete(); m_err = 0; m_exec = 0; m_skip = 0;
    end else if (!s.stall) begin
      fault = (s.push && s.pop) || (s.push && m_stack.size() == DEPTH) ||
              (s.pop && m_stack.size() == 0);
      if (fault) m_err = 1;
      else if (s.push) m_stack.push_back(m_flags);
      if (fault) begin
      end else if (s.pop) begin
        m_flags = m_stack.pop_back();
      end else if (go) begin
        if (s.fw[1]) m_flags[3:2] = s.alu[3:2];
        if (s.fw[0]) m_flags[1:0] = s.alu[1:0];
      end
      if (live) begin
        if (pass) m_exec = (m_exec < cnt_max) ? m_exec + 1 : m_exec;
        else      m_skip = (m_skip < cnt_max) ? m_skip + 1 : m_skip;
      end
    end
  endtask

  always @(negedge CLK) begin
    out_t a, e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = '{PCSrc, RegWrite, MemWrite, CondEx, Flags, StackEmpty, StackFull,
            StackErr, ExecCount, SkipCount};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs vec%0d: got pc=%b rw=%b mw=%b cx=%b fl=%h e=%b f=%b er=%b ex=%0d sk=%0d, want pc=%b rw=%b mw=%b cx=%b fl=%h e=%b f=%b er=%b ex=%0d sk=%0d",
                 vectors, a.pcsrc, a.regwrite, a.memwrite, a.condex, a.flags, a.empty,
                 a.full, a.err, a.exec, a.skip, e.pcsrc, e.regwrite, e.memwrite,
                 e.condex, e.flags, e.empty, e.full, e.err, e.exec, e.skip);
      end
    end
  end

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s = idle();
    s.rst = 1;
    apply(s);
  endtask

  function automatic stim_t set_flags(input bit [3:0] f);
    stim_t s = idle();
    s.valid = 1; s.cond = 4'hE; s.fw = 2'b11; s.alu = f;
    return s;
  endfunction

  initial begin
    stim_t s;
    Reset = 1; Valid = 0; Stall = 0; Flush = 0; Cond = 0; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; FlagPush = 0; FlagPop = 0;

    do_reset();
    do_reset();
    // EQ with Z clear: skipped
    s = idle(); s.valid = 1; s.regw = 1; apply(s);
    // set Z, then EQ store, then GT
    apply(set_flags(4'b0100));
    s = idle(); s.valid = 1; s.cond = 4'h0; s.memw = 1; s.pcs = 1; apply(s);
    s = idle(); s.valid = 1; s.cond = 4'hC; s.regw = 1; apply(s);
    // partial flag write: NZ only
    apply(set_flags(4'b1001));
    s = idle(); s.valid = 1; s.cond = 4'hE; s.fw = 2'b10; s.alu = 4'b0110; apply(s);
    s = idle(); s.valid = 1; s.cond = 4'hE; s.fw = 2'b11; s.alu = 4'b0011;
    s.regw = 1; s.nowr = 1; apply(s);
    apply(idle());

    // stack overflow / LIFO / underflow
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s = set_flags(4'(i + 3)); s.push = 1; apply(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(); s.pop = 1; apply(s);
    end
    apply(idle());

    // push/pop alongside flag writes
    do_reset();
    s = set_flags(4'b1111); s.push = 1; apply(s);
    s = set_flags(4'b1010); s.pop = 1; apply(s);
    s = idle(); s.push = 1; s.pop = 1; apply(s);
    apply(idle());

    // counter saturation, stall and flush
    do_reset();
    for (int i = 0; i < 5; i++) apply(set_flags(4'(i)));
    s = set_flags(4'b1111); s.pcs = 1; s.regw = 1; s.memw = 1; s.push = 1; s.stall = 1; apply(s);
    s.stall = 0; s.flush = 1; s.push = 0; apply(s);
    s = idle(); s.valid = 1; s.cond = 4'hF; apply(s);
    apply(idle());

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rst   = ($urandom_range(63) == 0);
      s.valid = ($urandom_range(3) != 0);
      s.stall = ($urandom_range(7) == 0);
      s.flush = ($urandom_range(7) == 0);
      s.cond  = 4'($urandom);
      s.alu   = 4'($urandom);
      s.fw    = 2'($urandom);
      s.pcs   = 1'($urandom);
      s.regw  = 1'($urandom);
      s.memw  = 1'($urandom);
      s.nowr  = ($urandom_range(3) == 0);
      s.push  = ($urandom_range(5) == 0);
      s.pop   = ($urandom_range(5) == 0);
      if ($urandom_range(15) == 0) s.push = 1;
      apply(s);
    end
    apply(idle());

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
Parametrised successor to the single-cycle ARM conditional logic. Evaluates all ARM condition codes against an internal NZCV flags register and gates PCSrc/RegWrite/MemWrite. Adds pipeline qualifiers (Valid/Stall/Flush), NoWrite for compare instructions, a saved-flags stack for exception entry/return, and saturating executed/skipped performance counters. Sits between the decoder and the register file, memory and PC mux.

Parameters:
FLAG_STACK_DEPTH, 4, number of saved NZCV entries (>=1).
PERF_CNT_W, 16, width of ExecCount/SkipCount (>=2).

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
Valid  in  1  instruction present in the execute stage this cycle
Stall  in  1  hold: no state update; outputs forced low
Flush  in  1  kill the current instruction; outputs low; no flag or counter update
Cond  in  4  instruction condition field
ALUFlags  in  4  {N,Z,C,V} from the ALU
FlagW  in  2  [1] writes N,Z; [0] writes C,V
PCS  in  1  instruction writes PC
RegW  in  1  instruction writes a register
MemW  in  1  instruction writes memory
NoWrite  in  1  CMP/CMN/TST/TEQ: suppress RegWrite
FlagPush  in  1  save current Flags to the stack (exception entry)
FlagPop  in  1  restore Flags from the stack top (exception return)
PCSrc  out  1  gated PCS
RegWrite  out  1  gated RegW
MemWrite  out  1  gated MemW
CondEx  out  1  condition passed for the current instruction (ungated)
Flags  out  4  current NZCV register
StackEmpty  out  1  no saved entries
StackFull  out  1  FLAG_STACK_DEPTH entries saved
StackErr  out  1  sticky error flag
ExecCount  out  PERF_CNT_W  executed-instruction count
SkipCount  out  PERF_CNT_W  skipped-instruction count

Behaviour:
- Reset values: Flags=0, stack pointer=0 (StackEmpty=1, StackFull=0), StackErr=0, both counters=0. Reset overrides every other input in the same cycle.
- CondEx is combinational from the registered Flags, not from ALUFlags. Codes 0000..1110 map to EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1.
- Cond=1111 (NV): CondEx=0.
- Define go = Valid & !Stall & !Flush & CondEx. All three output gates are zero-latency combinational:
  - PCSrc = go & PCS
  - RegWrite = go & RegW & !NoWrite
  - MemWrite = go & MemW
- Flag update at the clock edge when go: Flags[3:2] <= ALUFlags[3:2] if FlagW[1]; Flags[1:0] <= ALUFlags[1:0] if FlagW[0]. The new flags are visible to CondEx in the next cycle.
- Stack operations are evaluated only when !Stall. They are independent of Valid and CondEx, and Flush does not block them.
  - Push: stack[sp] <= Flags (the pre-update value); sp++. A flag write in the same cycle still applies to Flags.
  - Pop: Flags <= stack[sp-1]; sp--. Pop overrides any flag write in the same cycle.
  - Push when full, or Pop when empty: no change to the stack or Flags; StackErr <= 1.
  - Push and Pop together: no operation; StackErr <= 1.
- StackErr stays set until Reset.
- Counters update only when Valid & !Stall & !Flush. ExecCount increments if CondEx, otherwise SkipCount increments. Both saturate at all-ones and never wrap.
- Stall holds all state: no flag update, no stack operation, no counter update.

Test Plan:
- Reset, then Valid=1, Cond=0000 (EQ), RegW=1 -> CondEx=0, RegWrite=0, SkipCount=1, ExecCount=0.
- Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 next cycle; then Cond=0000, MemW=1 -> MemWrite=1; Cond=1100 (GT) -> CondEx=0.
- Flags=1001, FlagW=10, ALUFlags=0110 -> Flags=0101 (only NZ changed); CMP with NoWrite=1, RegW=1 -> RegWrite=0 while flags still update.
- DEPTH=4: five Pushes -> StackFull after the 4th, StackErr=1 after the 5th; four Pops return saved values in LIFO order; the next Pop leaves Flags unchanged.
- Push with FlagW=11, ALUFlags=1111, Flags=0000 -> stack top=0000, Flags=1111; Pop with FlagW=11 in the same cycle -> Flags=0000.
- PERF_CNT_W=2: five executed instructions -> ExecCount=3 (saturated); Stall=1 and Flush=1 cycles leave the counters unchanged and all outputs low.
